// File: rtl/cb_wb_arbiter.sv
// cb_wb_arbiter
// Round-robin arbiter that shares the single completion-buffer write port
// between the writeback requesters (0 = arith, 1 = mul, 2 = div, 3 = ls).
// The winning result is registered and presented for exactly one cycle.
//
// Ports
//   CLK, nRST                 clock (rising edge), asynchronous active-low reset
//   flush                     drop all in-flight results, no grant this cycle
//   cb_stall                  completion buffer cannot take a write this cycle
//   req_valid[NREQ]           per-requester result valid
//   req_ready[NREQ]           per-requester accept, one-hot or zero (combinational)
//   req_index/wdata/vd        flat per-requester payload, slice i = [i*W +: W]
//   req_exception, req_wen    per-requester flags
//   cb_ready                  registered one-cycle write pulse
//   cb_index/wdata/vd         registered payload of the last granted requester
//   cb_exception, cb_wen      registered flags of the last granted requester
//   cb_src                    registered id of the last granted requester
//   dbg_rr_ptr                current round-robin pointer (state observation)
//
// Handshake: a requester raises req_valid with a stable payload and holds both
// until it sees req_ready high in the same cycle; valid & ready on a rising
// edge is a transfer. req_ready never depends on anything but req_valid,
// rr_ptr, flush, cb_stall and reset, so there is no ready->valid loop.
module cb_wb_arbiter #(
  parameter int NUM  = 16,
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NUM),
  localparam int SW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               flush,
  input  logic               cb_stall,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*IW-1:0] req_index,
  input  logic [NREQ*32-1:0] req_wdata,
  input  logic [NREQ*5-1:0]  req_vd,
  input  logic [NREQ-1:0]    req_exception,
  input  logic [NREQ-1:0]    req_wen,
  output logic               cb_ready,
  output logic [IW-1:0]      cb_index,
  output logic [31:0]        cb_wdata,
  output logic [4:0]         cb_vd,
  output logic               cb_exception,
  output logic               cb_wen,
  output logic [SW-1:0]      cb_src,
  output logic [SW-1:0]      dbg_rr_ptr
);

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] gnt;
  logic          gnt_found;
  logic          xfer;
  logic [SW-1:0] ptr_next;

  // Requester that sits k positions above base, modulo NREQ. The wrap is
  // explicit so a non-power-of-two NREQ never indexes past the last requester.
  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return SW'(s);
  endfunction

  // First valid requester at or above rr_ptr, scanning upward with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[wrap_add(rr_ptr, k)]) begin
        gnt_found = 1'b1;
        gnt       = wrap_add(rr_ptr, k);
      end
    end
  end

  // Flush dominates stall; both block the grant. Reset also masks ready so
  // no requester believes it was accepted while the arbiter is held in reset.
  always_comb begin
    xfer      = gnt_found & ~flush & ~cb_stall & nRST;
    req_ready = '0;
    if (xfer) req_ready[gnt] = 1'b1;
    ptr_next  = (gnt == SW'(NREQ - 1)) ? '0 : gnt + SW'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr       <= '0;
      cb_ready     <= 1'b0;
      cb_index     <= '0;
      cb_wdata     <= '0;
      cb_vd        <= '0;
      cb_exception <= 1'b0;
      cb_wen       <= 1'b0;
      cb_src       <= '0;
    end else begin
      // xfer already excludes flush, so a flush cycle can never leave a pulse.
      cb_ready <= xfer;
      if (xfer) begin
        cb_index     <= req_index[int'(gnt)*IW +: IW];
        cb_wdata     <= req_wdata[int'(gnt)*32 +: 32];
        cb_vd        <= req_vd[int'(gnt)*5 +: 5];
        cb_exception <= req_exception[gnt];
        cb_wen       <= req_wen[gnt];
        cb_src       <= gnt;
        rr_ptr       <= ptr_next;
      end
    end
  end

  assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_cb_wb_arbiter.sv
module tb_cb_wb_arbiter;

  localparam int NUM  = 16;
  localparam int NREQ = 4;
  localparam int IW   = 4;
  localparam int SW   = 2;
  localparam int PW   = SW + IW + 32 + 5 + 1 + 1;

  logic               CLK;
  logic               nRST;
  logic               flush;
  logic               cb_stall;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*IW-1:0] req_index;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ*5-1:0]  req_vd;
  logic [NREQ-1:0]    req_exception;
  logic [NREQ-1:0]    req_wen;
  logic               cb_ready;
  logic [IW-1:0]      cb_index;
  logic [31:0]        cb_wdata;
  logic [4:0]         cb_vd;
  logic               cb_exception;
  logic               cb_wen;
  logic [SW-1:0]      cb_src;
  logic [SW-1:0]      dbg_rr_ptr;

  cb_wb_arbiter #(.NUM(NUM), .NREQ(NREQ)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .cb_stall(cb_stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_wdata(req_wdata), .req_vd(req_vd), .req_exception(req_exception),
    .req_wen(req_wen), .cb_ready(cb_ready), .cb_index(cb_index),
    .cb_wdata(cb_wdata), .cb_vd(cb_vd), .cb_exception(cb_exception),
    .cb_wen(cb_wen), .cb_src(cb_src), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- per-requester payload ----------------
  logic [IW-1:0] p_index [NREQ];
  logic [31:0]   p_wdata [NREQ];
  logic [4:0]    p_vd    [NREQ];
  logic          p_exc   [NREQ];
  logic          p_wen   [NREQ];

  always_comb begin
    req_index     = '0;
    req_wdata     = '0;
    req_vd        = '0;
    req_exception = '0;
    req_wen       = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_index[i*IW +: IW] = p_index[i];
      req_wdata[i*32 +: 32] = p_wdata[i];
      req_vd[i*5 +: 5]      = p_vd[i];
      req_exception[i]      = p_exc[i];
      req_wen[i]            = p_wen[i];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  int            n_cmp;
  int            n_err;
  int            m_ptr;     // requester with top priority this cycle
  logic          m_ready;   // expected cb_ready
  logic [PW-1:0] m_cb;      // expected {src,index,wdata,vd,exc,wen}
  logic [PW-1:0] exp_q[$];  // one entry per expected write pulse

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_payload(input int i);
    p_index[i] = IW'($urandom_range(NUM - 1, 0));
    p_wdata[i] = $urandom;
    p_vd[i]    = 5'($urandom_range(31, 0));
    p_exc[i]   = 1'($urandom_range(1, 0));
    p_wen[i]   = 1'($urandom_range(1, 0));
  endtask

  function automatic logic [PW-1:0] pack_req(input int i);
    return {SW'(i), p_index[i], p_wdata[i], p_vd[i], p_exc[i], p_wen[i]};
  endfunction

  // One cycle: drive at the falling edge, check ready mid-cycle, let the
  // rising edge happen, update the model, then check registered outputs.
  task automatic step(input logic [NREQ-1:0] v, input logic f, input logic s);
    int            g;
    logic [NREQ-1:0] exp_rdy;
    req_valid = v;
    flush     = f;
    cb_stall  = s;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    exp_rdy = '0;
    if (g >= 0 && !f && !s) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("ready_onehot0", 64'($onehot0(req_ready)), 64'(1));
    chk("ready_implies_valid", 64'(req_ready & ~req_valid), 64'(0));
    @(posedge CLK);
    if (exp_rdy != '0) begin
      m_ready = 1'b1;
      m_cb    = pack_req(g);
      exp_q.push_back(m_cb);
      m_ptr   = (g + 1) % NREQ;
    end else begin
      m_ready = 1'b0;
    end
    @(negedge CLK);
    chk("cb_ready", 64'(cb_ready), 64'(m_ready));
    chk("cb_payload", 64'({cb_src, cb_index, cb_wdata, cb_vd, cb_exception, cb_wen}), 64'(m_cb));
    chk("rr_ptr", 64'(dbg_rr_ptr), 64'(m_ptr));
    if (cb_ready) begin
      if (exp_q.size() == 0) chk("sb_orphan_pulse", 64'(cb_ready), 64'(0));
      else chk("sb_pulse", 64'({cb_src, cb_index, cb_wdata, cb_vd, cb_exception, cb_wen}),
               64'(exp_q.pop_front()));
    end
    // A requester keeps its payload until accepted; idle or accepted ones get fresh data.
    for (int i = 0; i < NREQ; i++)
      if (!v[i] || (exp_rdy[i] == 1'b1)) new_payload(i);
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_ready = 1'b0;
    m_cb    = '0;
    exp_q.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < NREQ; i++) new_payload(i);
    nRST = 1'b0; flush = 1'b0; cb_stall = 1'b0; req_valid = '0;
    model_reset();
    repeat (2) @(negedge CLK);

    // reset state, including ready masked while in reset
    req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_cb_ready", 64'(cb_ready), 64'(0));
    chk("rst_payload", 64'({cb_src, cb_index, cb_wdata, cb_vd, cb_exception, cb_wen}), 64'(0));
    chk("rst_rr_ptr", 64'(dbg_rr_ptr), 64'(0));
    req_valid = '0;
    @(negedge CLK);
    nRST = 1'b1;

    // single requester 2 with a known payload
    p_index[2] = 4'd5; p_wdata[2] = 32'hDEADBEEF; p_vd[2] = 5'd7;
    step(4'b0100, 1'b0, 1'b0);
    chk("t1_cb_ready", 64'(cb_ready), 64'(1));
    chk("t1_cb_index", 64'(cb_index), 64'(5));
    chk("t1_cb_wdata", 64'(cb_wdata), 64'h0000_0000_DEAD_BEEF);
    chk("t1_cb_vd", 64'(cb_vd), 64'(7));
    chk("t1_cb_src", 64'(cb_src), 64'(2));
    chk("t1_rr_ptr", 64'(dbg_rr_ptr), 64'(3));

    // move pointer to 0, then all four valid: 0,1,2,3,0,1,2,3 back to back
    step(4'b1000, 1'b0, 1'b0);
    chk("t2_start_ptr", 64'(dbg_rr_ptr), 64'(0));
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      chk("t2_fair_src", 64'(cb_src), 64'(i % NREQ));
      chk("t2_fair_ready", 64'(cb_ready), 64'(1));
    end

    // wrap: pointer at 3 with valid 1001 -> 3 then 0
    step(4'b0100, 1'b0, 1'b0);
    step(4'b1001, 1'b0, 1'b0);
    chk("t3_src_a", 64'(cb_src), 64'(3));
    chk("t3_ptr_a", 64'(dbg_rr_ptr), 64'(0));
    step(4'b1001, 1'b0, 1'b0);
    chk("t3_src_b", 64'(cb_src), 64'(0));
    chk("t3_ptr_b", 64'(dbg_rr_ptr), 64'(1));

    // stall holds requester 1 off for 3 cycles, then it is granted
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 1'b0, 1'b1);
      chk("t4_stall_ready", 64'(cb_ready), 64'(0));
    end
    step(4'b0010, 1'b0, 1'b0);
    chk("t4_release_ready", 64'(cb_ready), 64'(1));
    chk("t4_release_src", 64'(cb_src), 64'(1));

    // transfer of requester 0, then a flush window: no further pulse, pointer held
    step(4'b0001, 1'b0, 1'b0);
    chk("t5_xfer_src", 64'(cb_src), 64'(0));
    step(4'b1111, 1'b1, 1'b0);
    chk("t5_flush_ready", 64'(cb_ready), 64'(0));
    chk("t5_flush_ptr", 64'(dbg_rr_ptr), 64'(1));
    step(4'b0011, 1'b1, 1'b1);
    chk("t5_flush_stall_ready", 64'(cb_ready), 64'(0));
    chk("t5_flush_stall_ptr", 64'(dbg_rr_ptr), 64'(1));

    // randomized traffic against the model
    for (int i = 0; i < 300; i++)
      step(NREQ'($urandom_range(15, 0)), ($urandom_range(7, 0) == 0),
           ($urandom_range(5, 0) == 0));

    // asynchronous reset while a pulse is on the outputs
    step(4'b1111, 1'b0, 1'b0);
    chk("t6_pre_ready", 64'(cb_ready), 64'(1));
    #2 nRST = 1'b0;
    #1;
    chk("t6_rst_cb_ready", 64'(cb_ready), 64'(0));
    chk("t6_rst_payload", 64'({cb_src, cb_index, cb_wdata, cb_vd, cb_exception, cb_wen}), 64'(0));
    chk("t6_rst_ptr", 64'(dbg_rr_ptr), 64'(0));
    chk("t6_rst_req_ready", 64'(req_ready), 64'(0));
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    step(4'b1111, 1'b0, 1'b0);
    chk("t6_first_src", 64'(cb_src), 64'(0));
    chk("t6_sb_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout cycles_exceeded observed=1 expected=0");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
